// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: parses SPI command frames (opcode, addr, len, data, chk)
// into accesses on a small byte register file and supplies the next MISO byte.
module spi_cmd_decoder #(
    parameter int unsigned ADDR_W  = 4,
    parameter logic [7:0]  RST_VAL = 8'h00
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         msg_start,
    input  logic                         msg_end,
    input  logic                         rx_valid,
    input  logic [7:0]                   rx_data,
    output logic [7:0]                   tx_data,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [7:0]                   wr_data,
    output logic                         frame_ok,
    output logic                         frame_err,
    output logic [8*(1<<ADDR_W)-1:0]     regs_flat
);

    localparam int unsigned NREGS    = 1 << ADDR_W;
    localparam logic [7:0]  OP_WRITE = 8'h01;
    localparam logic [7:0]  OP_READ  = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPCODE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CHK,
        S_DISCARD
    } state_e;

    state_e                     state_q, state_d, byte_state;
    logic [7:0]                 xor_q, xor_d;
    logic [ADDR_W-1:0]          ptr_q, ptr_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic                       is_read_q, is_read_d;
    logic [NREGS-1:0][7:0]      regs_q, regs_d;
    logic [7:0]                 tx_q, tx_d;
    logic                       wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
    logic [7:0]                 wr_data_q, wr_data_d;
    logic                       ok_q, ok_d;
    logic                       err_q, err_d;
    logic [3:0]                 err_cnt_q, err_cnt_d;
    logic                       last_ok_q, last_ok_d;

    logic                       rx_acc;
    logic                       opc_ok;
    logic                       byte_ok, byte_err;
    logic                       rd_load;
    logic                       abort;
    logic [7:0]                 status;

    // msg_start drops any byte arriving in the same cycle
    assign rx_acc = rx_valid & ~msg_start;
    assign opc_ok = (rx_data == OP_WRITE) || (rx_data == OP_READ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            xor_q     <= 8'h00;
            ptr_q     <= '0;
            cnt_q     <= 8'h00;
            is_read_q <= 1'b0;
            regs_q    <= {NREGS{RST_VAL}};
            tx_q      <= 8'h00;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 4'h0;
            last_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            xor_q     <= xor_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            is_read_q <= is_read_d;
            regs_q    <= regs_d;
            tx_q      <= tx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            last_ok_q <= last_ok_d;
        end
    end

    // byte_state is where the received byte takes us; msg_end then applies to it
    always_comb begin
        byte_state = state_q;
        if (rx_acc) begin
            case (state_q)
                S_OPCODE: byte_state = opc_ok ? S_ADDR : S_DISCARD;
                S_ADDR:   byte_state = S_LEN;
                S_LEN:    byte_state = (rx_data == 8'h00) ? S_CHK : S_DATA;
                S_DATA:   byte_state = (cnt_q == 8'd1) ? S_CHK : S_DATA;
                S_CHK:    byte_state = S_DISCARD;
                default:  byte_state = state_q;
            endcase
        end
        state_d = byte_state;
        if (msg_start) begin
            state_d = S_OPCODE;
        end else if (msg_end) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        byte_ok   = 1'b0;
        byte_err  = 1'b0;
        rd_load   = 1'b0;
        xor_d     = xor_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        is_read_d = is_read_q;
        regs_d    = regs_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (rx_acc) begin
            case (state_q)
                S_OPCODE: begin
                    xor_d     = xor_q ^ rx_data;
                    is_read_d = (rx_data == OP_READ);
                    byte_err  = ~opc_ok;
                end
                S_ADDR: begin
                    xor_d   = xor_q ^ rx_data;
                    ptr_d   = rx_data[ADDR_W-1:0];
                    rd_load = is_read_q;
                end
                S_LEN: begin
                    xor_d = xor_q ^ rx_data;
                    cnt_d = rx_data;
                end
                S_DATA: begin
                    xor_d   = xor_q ^ rx_data;
                    ptr_d   = ptr_q + 1'b1;
                    cnt_d   = cnt_q - 8'd1;
                    rd_load = is_read_q;
                    if (!is_read_q) begin
                        regs_d[ptr_q] = rx_data;
                        wr_en_d       = 1'b1;
                        wr_addr_d     = ptr_q;
                        wr_data_d     = rx_data;
                    end
                end
                S_CHK: begin
                    byte_ok  = (rx_data == xor_q);
                    byte_err = (rx_data != xor_q);
                end
                default: ;
            endcase
        end
        if (msg_start) begin
            xor_d = 8'h00;
        end

        abort = msg_end & ~msg_start &
                (byte_state inside {S_ADDR, S_LEN, S_DATA, S_CHK});
        err_d = byte_err | abort;
        ok_d  = byte_ok;

        err_cnt_d = err_cnt_q;
        if (err_d && err_cnt_q != 4'hF) begin
            err_cnt_d = err_cnt_q + 4'h1;
        end
        last_ok_d = last_ok_q;
        if (err_d) begin
            last_ok_d = 1'b0;
        end else if (ok_d) begin
            last_ok_d = 1'b1;
        end
        status = {last_ok_d, 3'b000, err_cnt_d};

        tx_d = tx_q;
        if (msg_start || msg_end || rx_acc) begin
            tx_d = status;
        end
        if (rd_load && !msg_end) begin
            tx_d = regs_q[ptr_d];
        end
    end

    assign tx_data   = tx_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign regs_flat = regs_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: directed frames plus random frames checked
// against a frame-position reference model of the command protocol.
module tb_spi_cmd_decoder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         msg_start, msg_end, rx_valid;
    logic [7:0]   rx_data;
    logic [7:0]   tx_data;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         frame_ok, frame_err;
    logic [127:0] regs_flat;

    spi_cmd_decoder #(.ADDR_W(4), .RST_VAL(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .msg_start (msg_start),
        .msg_end   (msg_end),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_data   (tx_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .regs_flat (regs_flat)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [7:0] m_regs [16];
    logic [7:0] m_tx;
    int         m_err;
    bit         m_ok;
    bit         act, dead;
    logic [7:0] q [$];
    bit         e_wr, e_ok, e_err;
    logic [3:0] e_wa;
    logic [7:0] e_wd;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack_regs();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = m_regs[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_tx = 8'h00; m_err = 0; m_ok = 0;
        act = 0; dead = 0; q.delete();
        e_wr = 0; e_ok = 0; e_err = 0;
    endtask

    // frame position k decides the role of each accepted byte
    task automatic model(input bit ms, input bit me, input bit rv,
                         input logic [7:0] rd);
        int k, len, a;
        bit rdld;
        logic [3:0] rda;
        logic [7:0] x;
        e_wr = 0; e_ok = 0; e_err = 0; rdld = 0; rda = 0;
        if (ms) begin
            act = 1; dead = 0; q.delete();
        end else begin
            if (rv && act && !dead) begin
                k = q.size();
                if (k == 0) begin
                    if (rd != 8'h01 && rd != 8'h02) begin
                        e_err = 1; dead = 1;
                    end
                end else if (k == 1) begin
                    if (q[0] == 8'h02) begin
                        rdld = 1; rda = rd[3:0];
                    end
                end else if (k >= 3) begin
                    len = int'(q[2]);
                    if (k < 3 + len) begin
                        a = (int'(q[1]) + k - 3) % 16;
                        if (q[0] == 8'h01) begin
                            m_regs[a] = rd;
                            e_wr = 1; e_wa = 4'(a); e_wd = rd;
                        end else begin
                            rdld = 1; rda = 4'((a + 1) % 16);
                        end
                    end else begin
                        x = 8'h00;
                        foreach (q[i]) x = x ^ q[i];
                        if (rd == x) e_ok = 1;
                        else e_err = 1;
                        dead = 1;
                    end
                end
                q.push_back(rd);
            end
            if (me) begin
                if (act && !dead && q.size() > 0) e_err = 1;
                act = 0;
            end
        end
        if (e_err) begin
            if (m_err < 15) m_err++;
            m_ok = 0;
        end else if (e_ok) begin
            m_ok = 1;
        end
        if (ms || me || rv) m_tx = {m_ok, 3'b000, 4'(m_err)};
        if (rdld && !me) m_tx = m_regs[rda];
    endtask

    task automatic step(input bit ms, input bit me, input bit rv,
                        input logic [7:0] rd);
        msg_start = ms; msg_end = me; rx_valid = rv; rx_data = rd;
        model(ms, me, rv, rd);
        @(posedge clk);
        #1;
        msg_start = 0; msg_end = 0; rx_valid = 0;
        check("tx_data", tx_data, m_tx);
        check("wr_en", wr_en, e_wr);
        if (e_wr) begin
            check("wr_addr", wr_addr, e_wa);
            check("wr_data", wr_data, e_wd);
        end
        check("frame_ok", frame_ok, e_ok);
        check("frame_err", frame_err, e_err);
        check("regs", regs_flat, pack_regs());
    endtask

    task automatic send(input logic [7:0] b [$], input bit close);
        step(1, 0, 0, 8'h00);
        foreach (b[i]) begin
            step(0, 0, 1, b[i]);
            step(0, 0, 0, 8'h00);
        end
        if (close) step(0, 1, 0, 8'h00);
    endtask

    task automatic rand_frame();
        logic [7:0] b [$];
        logic [7:0] x;
        int r, len, n;
        r = $urandom_range(0, 15);
        b.push_back(r < 7 ? 8'h01 : (r < 13 ? 8'h02 : 8'($urandom)));
        b.push_back(8'($urandom));
        len = $urandom_range(0, 4);
        b.push_back(8'(len));
        for (int i = 0; i < len; i++) b.push_back(8'($urandom));
        x = 8'h00;
        foreach (b[i]) x = x ^ b[i];
        b.push_back($urandom_range(0, 3) != 0 ? x : 8'($urandom));
        if ($urandom_range(0, 3) == 0) b.push_back(8'($urandom));
        n = b.size();
        if ($urandom_range(0, 5) == 0) n = $urandom_range(0, b.size());
        if ($urandom_range(0, 7) == 0) step(1, 0, 1, 8'($urandom));
        else step(1, 0, 0, 8'h00);
        for (int i = 0; i < n; i++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) step(0, 0, 0, 8'h00);
            if (i == n - 1 && $urandom_range(0, 3) == 0) begin
                step(0, 1, 1, b[i]);
                return;
            end
            step(0, 0, 1, b[i]);
        end
        if ($urandom_range(0, 9) != 0) step(0, 1, 0, 8'h00);
        step(0, 0, 0, 8'h00);
    endtask

    initial begin
        logic [7:0] f [$];
        rst_n = 0; msg_start = 0; msg_end = 0; rx_valid = 0; rx_data = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        check("rst_tx", tx_data, 8'h00);
        check("rst_regs", regs_flat, 128'h0);
        check("rst_pulses", {wr_en, frame_ok, frame_err}, 3'b000);
        check("rst_wr", {wr_addr, wr_data}, 12'h000);

        step(0, 0, 1, 8'h5A);
        step(0, 0, 0, 8'h00);
        check("noframe_tx", tx_data, 8'h00);

        f = {8'h01, 8'h02, 8'h02, 8'hAA, 8'h55, 8'hFE};
        send(f, 1);
        check("wr_reg2", regs_flat[23:16], 8'hAA);
        check("wr_reg3", regs_flat[31:24], 8'h55);
        check("wr_status", tx_data, 8'h80);

        f = {8'h02, 8'h02, 8'h02, 8'h00, 8'h00, 8'h02};
        send(f, 1);

        f = {8'h01, 8'h0F, 8'h02, 8'h11, 8'h22, 8'h3F};
        send(f, 1);
        check("wrap_reg15", regs_flat[127:120], 8'h11);
        check("wrap_reg0", regs_flat[7:0], 8'h22);

        f = {8'h01, 8'h02, 8'h02, 8'hAA, 8'h55, 8'h00};
        send(f, 1);
        check("badchk_status", tx_data, 8'h01);
        f = {8'h01, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 16; i++) send(f, 1);
        check("sat_status", tx_data, 8'h0F);

        f = {8'h07, 8'h01, 8'h01, 8'h05, 8'h03};
        send(f, 1);
        f = {8'h01, 8'h03};
        send(f, 1);

        step(1, 0, 1, 8'hAB);
        f = {8'h01, 8'h05, 8'h01, 8'h77, 8'h72};
        foreach (f[i]) step(0, 0, 1, f[i]);
        step(0, 1, 0, 8'h00);
        check("coinc_reg5", regs_flat[47:40], 8'h77);

        for (int i = 0; i < 300; i++) rand_frame();

        f = {8'h01, 8'h00, 8'h04, 8'hC3, 8'h3C};
        send(f, 0);
        step(0, 0, 1, 8'h99);
        #3 rst_n = 0;
        #1;
        check("arst_regs", regs_flat, 128'h0);
        check("arst_tx", tx_data, 8'h00);
        check("arst_pulses", {wr_en, frame_ok, frame_err}, 3'b000);
        check("arst_wr", {wr_addr, wr_data}, 12'h000);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        f = {8'h01, 8'h04, 8'h01, 8'h5D, 8'h59};
        send(f, 1);
        check("post_rst_reg4", regs_flat[39:32], 8'h5D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
- Downstream consumer of the SPI slave's receive path: takes received bytes plus message start/end strobes and parses command frames.
- Executes each frame against a small byte register file.
- Supplies the byte the SPI slave shifts out on MISO at the next byte boundary.
- Converts the raw SPI byte link into a register read/write protocol for the LA104 host.

Parameters:
- ADDR_W, 4, register address width; NREGS = 2^ADDR_W byte registers.
- RST_VAL, 8'h00, reset value of every register.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- msg_start  in  1  one-cycle pulse at SSEL assertion.
- msg_end  in  1  one-cycle pulse at SSEL deassertion.
- rx_valid  in  1  one-cycle pulse: a byte has been received.
- rx_data  in  8  received byte, valid while rx_valid=1.
- tx_data  out  8  byte for the slave to transmit next; registered.
- wr_en  out  1  one-cycle pulse, register write performed.
- wr_addr  out  ADDR_W  address of the write.
- wr_data  out  8  data of the write.
- frame_ok  out  1  one-cycle pulse, frame completed with good checksum.
- frame_err  out  1  one-cycle pulse, frame aborted or checksum bad.
- regs_flat  out  8*NREGS  register file contents; reg i is at bits [8i+7:8i].

Behaviour:
- Reset state (async, rst_n=0):
  - state=IDLE, all regs=RST_VAL, tx_data=8'h00.
  - wr_en=0, frame_ok=0, frame_err=0, wr_addr=0, wr_data=0.
  - err_cnt=0, last_ok=0.
- Frame format: OPCODE, ADDR, LEN, then LEN data bytes, then CHK.
  - CHK = XOR of all preceding bytes in the frame, including dummy bytes of a READ.
  - Opcodes: 8'h01 WRITE, 8'h02 READ; any other value is invalid.
- FSM states: IDLE, ADDR, LEN, DATA, CHK, DISCARD.
  - msg_start (any state) -> ADDR-expecting opcode phase, i.e. OPCODE. Clears the running XOR and sets tx_data=STATUS.
  - OPCODE + rx_valid: valid opcode -> ADDR; invalid opcode -> DISCARD with frame_err pulse.
  - ADDR + rx_valid: ptr=rx_data[ADDR_W-1:0]; next state is LEN.
  - LEN + rx_valid: cnt=rx_data. cnt=0 -> CHK, else -> DATA.
  - DATA + rx_valid:
    - WRITE: regs[ptr]<=rx_data; wr_en pulses with wr_addr=ptr and wr_data=rx_data.
    - ptr<=ptr+1, wrapping modulo NREGS; cnt<=cnt-1; when cnt reaches 0 -> CHK.
  - CHK + rx_valid: if rx_data == XOR, pulse frame_ok and set last_ok=1; else pulse frame_err. Next state is DISCARD.
  - DISCARD: ignores all rx_valid until msg_start.
  - msg_end while in OPCODE: return to IDLE silently (empty frame).
  - msg_end while in ADDR/LEN/DATA/CHK: frame_err pulse, then IDLE.
  - msg_end while in DISCARD: IDLE, no pulse.
- READ tx_data: the cycle after the ADDR byte and after each DATA byte, tx_data=regs[ptr] using the updated ptr. Otherwise tx_data=STATUS.
- STATUS byte: {last_ok, 3'b000, err_cnt[3:0]}.
  - err_cnt increments on every frame_err and saturates at 15.
  - frame_err clears last_ok.
- Latency: all outputs update exactly 1 clk after the rx_valid or msg_* pulse that causes them.
  - The upstream slave samples tx_data no earlier than 2 clks after rx_valid.
- Simultaneous events:
  - msg_start and rx_valid in the same cycle: msg_start wins and the byte is dropped.
  - msg_end and rx_valid in the same cycle: the byte is processed first, then msg_end applies.
  - A CHK byte completing on that cycle gives frame_ok only; no frame_err.
- Writes are not rolled back on a bad checksum or an abort.
- Reset mid-frame: immediate return to reset state; partial writes are lost because regs return to RST_VAL.

Test Plan:
- Reset, then one full byte transfer with no frame: tx_data=8'h00, regs_flat all 0, no pulses.
- WRITE frame 01 02 02 AA 55 FE: wr_en pulses with (2,AA) then (3,55); regs[2]=AA, regs[3]=55; frame_ok pulses; STATUS=8'h80.
- READ frame 02 02 02 00 00 02 after the previous write: tx_data=AA after the ADDR byte and 55 after the first dummy; frame_ok pulses; no wr_en.
- Wrap-around, WRITE 01 0F 02 11 22 CHK=3F: regs[15]=11, regs[0]=22.
- WRITE frame with CHK=00 instead of FE: writes still occur; frame_err pulses; STATUS=8'h01. Sixteen further bad frames leave err_cnt at F.
- Error and abort cases:
  - Opcode 07: frame_err pulses immediately and following bytes are ignored.
  - msg_end after 2 bytes: frame_err pulses.
  - msg_start coincident with rx_valid: the byte is dropped and the next byte is parsed as OPCODE.
  - rst_n low mid-DATA: all outputs return to reset values asynchronously.
